// File: rtl/esp32_boot_sequencer.sv
// ESP32 EN / GPIO0 boot-strap sequencer: powers the module up, restarts it into
// normal or download mode on request, and owns GPIO0 and UART TX while the ESP32 is down.
module esp32_boot_sequencer #(
    parameter int POWERUP_CYCLES    = 2800000,
    parameter int RESET_CYCLES      = 280000,
    parameter int STRAP_HOLD_CYCLES = 140000,
    parameter int CNT_W             = 24
) (
    input  logic clk_peripheral,
    input  logic resetn,
    input  logic boot_req,
    input  logic boot_mode,
    output logic busy,
    output logic done,
    input  logic core_gpio0_o,
    input  logic core_gpio0_en,
    input  logic core_uart_tx,
    output logic esp_en,
    output logic esp_gpio0_o,
    output logic esp_gpio0_t,
    output logic esp_uart_tx
);

    typedef enum logic [1:0] {
        S_POWERUP,
        S_HOLD_RST,
        S_STRAP,
        S_RUN
    } state_t;

    localparam logic [CNT_W-1:0] PU_LOAD    = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] STRAP_LOAD = CNT_W'(STRAP_HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             en_q, en_d;
    logic             gpio0_o_q, gpio0_o_d;
    logic             gpio0_t_q, gpio0_t_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk_peripheral or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_POWERUP;
            cnt_q     <= PU_LOAD;
            mode_q    <= 1'b0;
            en_q      <= 1'b0;
            gpio0_o_q <= 1'b0;
            gpio0_t_q <= 1'b1;
            tx_q      <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            en_q      <= en_d;
            gpio0_o_q <= gpio0_o_d;
            gpio0_t_q <= gpio0_t_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next state; a counter loaded with N-1 leaves its state on the edge it reads 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            S_POWERUP: begin
                if (cnt_q == '0) state_d = S_RUN;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_HOLD_RST: begin
                if (cnt_q == '0) begin
                    state_d = S_STRAP;
                    cnt_d   = STRAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STRAP: begin
                if (cnt_q == '0) state_d = S_RUN;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_RUN: begin
                if (boot_req) begin
                    state_d = S_HOLD_RST;
                    cnt_d   = RST_LOAD;
                    mode_d  = boot_mode;
                end
            end
            default: begin
                state_d = S_POWERUP;
                cnt_d   = PU_LOAD;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q after the edge.
    always_comb begin
        en_d      = (state_d == S_STRAP) || (state_d == S_RUN);
        busy_d    = (state_d != S_RUN);
        done_d    = (state_d == S_RUN) && (state_q != S_RUN);
        gpio0_o_d = 1'b0;
        gpio0_t_d = 1'b1;
        tx_d      = 1'b1;
        case (state_d)
            S_HOLD_RST, S_STRAP: begin
                gpio0_o_d = 1'b0;
                gpio0_t_d = ~mode_d;
                tx_d      = 1'b1;
            end
            S_RUN: begin
                gpio0_o_d = core_gpio0_o;
                gpio0_t_d = ~core_gpio0_en;
                tx_d      = core_uart_tx;
            end
            default: begin
                gpio0_o_d = 1'b0;
                gpio0_t_d = 1'b1;
                tx_d      = 1'b1;
            end
        endcase
    end

    assign esp_en      = en_q;
    assign esp_gpio0_o = gpio0_o_q;
    assign esp_gpio0_t = gpio0_t_q;
    assign esp_uart_tx = tx_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_esp32_boot_sequencer.sv
// Frame-by-frame scoreboard bench for esp32_boot_sequencer with short cycle parameters.
module tb_esp32_boot_sequencer;

    logic clk;
    logic resetn;
    logic boot_req;
    logic boot_mode;
    logic busy;
    logic done;
    logic core_gpio0_o;
    logic core_gpio0_en;
    logic core_uart_tx;
    logic esp_en;
    logic esp_gpio0_o;
    logic esp_gpio0_t;
    logic esp_uart_tx;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [5:0] v;
        string      tag;
    } frame_t;

    frame_t sb[$];

    esp32_boot_sequencer #(
        .POWERUP_CYCLES   (8),
        .RESET_CYCLES     (4),
        .STRAP_HOLD_CYCLES(3),
        .CNT_W            (4)
    ) dut (
        .clk_peripheral(clk),
        .resetn        (resetn),
        .boot_req      (boot_req),
        .boot_mode     (boot_mode),
        .busy          (busy),
        .done          (done),
        .core_gpio0_o  (core_gpio0_o),
        .core_gpio0_en (core_gpio0_en),
        .core_uart_tx  (core_uart_tx),
        .esp_en        (esp_en),
        .esp_gpio0_o   (esp_gpio0_o),
        .esp_gpio0_t   (esp_gpio0_t),
        .esp_uart_tx   (esp_uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed bit order: {en, gpio0_o, gpio0_t, tx, busy, done}
    function automatic logic [5:0] outs();
        return {esp_en, esp_gpio0_o, esp_gpio0_t, esp_uart_tx, busy, done};
    endfunction

    task automatic push(input string tag, input logic en, input logic o, input logic t,
                        input logic tx, input logic bz, input logic dn);
        frame_t f;
        f.v   = {en, o, t, tx, bz, dn};
        f.tag = tag;
        sb.push_back(f);
    endtask

    task automatic push_pu(input int n);
        for (int k = 0; k < n; k++) push("powerup", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic push_hold(input logic mode, input int n);
        for (int k = 0; k < n; k++) push("hold_rst", 1'b0, 1'b0, ~mode, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic push_strap(input logic mode, input int n);
        for (int k = 0; k < n; k++) push("strap", 1'b1, 1'b0, ~mode, 1'b1, 1'b1, 1'b0);
    endtask

    // Run frame expected from the core values the bench is currently driving.
    task automatic push_run(input logic dn);
        push(dn ? "run_first" : "run", 1'b1, core_gpio0_o, ~core_gpio0_en, core_uart_tx, 1'b0, dn);
    endtask

    task automatic test_reset();
        frame_t f;
        logic [5:0] obs;
        int i;
        resetn = 1'b0; boot_req = 1'b0; boot_mode = 1'b0;
        core_gpio0_o = 1'b1; core_gpio0_en = 1'b1; core_uart_tx = 1'b1;
        push_pu(3);
        push_pu(7);
        push_run(1'b1);
        push_run(1'b0);
        i = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            f = sb.pop_front();
            obs = outs();
            n_tests++;
            if (obs !== f.v) begin
                n_fail++;
                $display("FAIL test_reset %s frame %0d: got %b required %b", f.tag, i, obs, f.v);
            end
            if (i == 0) core_uart_tx = 1'b0;
            if (i == 1) core_uart_tx = 1'b1;
            if (i == 2) resetn = 1'b1;
            i++;
        end
        $display("[TB] test_reset: %0d frames checked", i);
    endtask

    task automatic test_restart(input string name, input logic mode);
        frame_t f;
        logic [5:0] obs;
        int i;
        core_gpio0_o = mode; core_gpio0_en = 1'b1; core_uart_tx = 1'b0;
        boot_req = 1'b1; boot_mode = mode;
        push_hold(mode, 4);
        push_strap(mode, 3);
        push_run(1'b1);
        push_run(1'b0);
        i = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            f = sb.pop_front();
            obs = outs();
            n_tests++;
            if (obs !== f.v) begin
                n_fail++;
                $display("FAIL %s %s frame %0d: got %b required %b", name, f.tag, i, obs, f.v);
            end
            if (i == 0) begin
                boot_req  = 1'b0;
                boot_mode = ~mode;
            end
            i++;
        end
        $display("[TB] %s: %0d frames checked", name, i);
    endtask

    task automatic test_ignore_and_passthru();
        frame_t f;
        logic [5:0] obs;
        int i;
        core_gpio0_o = 1'b1; core_gpio0_en = 1'b1; core_uart_tx = 1'b0;
        boot_req = 1'b1; boot_mode = 1'b1;
        push_hold(1'b1, 4);
        push_strap(1'b1, 3);
        push_run(1'b1);
        push_run(1'b0);
        i = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            f = sb.pop_front();
            obs = outs();
            n_tests++;
            if (obs !== f.v) begin
                n_fail++;
                $display("FAIL test_ignore %s frame %0d: got %b required %b", f.tag, i, obs, f.v);
            end
            if (i == 0) boot_req = 1'b0;
            if (i == 1) begin
                boot_req = 1'b1; boot_mode = 1'b0; core_gpio0_en = 1'b0;
            end
            if (i == 2) begin
                boot_req = 1'b0; core_gpio0_en = 1'b1;
            end
            i++;
        end
        // Pass-through: each core change shows one edge later.
        for (int k = 0; k < 6; k++) begin
            core_gpio0_o  = 1'($urandom_range(0, 1));
            core_gpio0_en = 1'($urandom_range(0, 1));
            core_uart_tx  = (k % 2 == 0);
            push_run(1'b0);
            @(negedge clk);
            f = sb.pop_front();
            obs = outs();
            n_tests++;
            if (obs !== f.v) begin
                n_fail++;
                $display("FAIL test_passthru %s step %0d: got %b required %b", f.tag, k, obs, f.v);
            end
        end
        $display("[TB] test_ignore_and_passthru: %0d frames checked", i + 6);
    endtask

    task automatic test_back_to_back();
        frame_t f;
        logic [5:0] obs;
        int i;
        core_gpio0_o = 1'b0; core_gpio0_en = 1'b1; core_uart_tx = 1'b1;
        boot_req = 1'b1; boot_mode = 1'b1;
        for (int p = 0; p < 2; p++) begin
            push_hold(1'b1, 4);
            push_strap(1'b1, 3);
            push_run(1'b1);
        end
        push_run(1'b0);
        i = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            f = sb.pop_front();
            obs = outs();
            n_tests++;
            if (obs !== f.v) begin
                n_fail++;
                $display("FAIL test_back_to_back %s frame %0d: got %b required %b", f.tag, i, obs, f.v);
            end
            if (i == 15) boot_req = 1'b0;
            i++;
        end
        $display("[TB] test_back_to_back: %0d frames checked", i);
    endtask

    task automatic test_async_reset();
        frame_t f;
        logic [5:0] obs;
        int i;
        boot_req = 1'b1; boot_mode = 1'b1;
        push_hold(1'b1, 4);
        push_strap(1'b1, 1);
        i = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            f = sb.pop_front();
            obs = outs();
            n_tests++;
            if (obs !== f.v) begin
                n_fail++;
                $display("FAIL test_async_reset %s frame %0d: got %b required %b", f.tag, i, obs, f.v);
            end
            if (i == 0) boot_req = 1'b0;
            i++;
        end
        #2;
        resetn = 1'b0;
        #1;
        push_pu(1);
        f = sb.pop_front();
        obs = outs();
        n_tests++;
        if (obs !== f.v) begin
            n_fail++;
            $display("FAIL test_async_reset immediate: got %b required %b", obs, f.v);
        end
        core_gpio0_o = 1'b1; core_gpio0_en = 1'b0; core_uart_tx = 1'b1;
        push_pu(2);
        push_pu(7);
        push_run(1'b1);
        push_run(1'b0);
        i = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            f = sb.pop_front();
            obs = outs();
            n_tests++;
            if (obs !== f.v) begin
                n_fail++;
                $display("FAIL test_async_reset %s after frame %0d: got %b required %b", f.tag, i, obs, f.v);
            end
            if (i == 1) resetn = 1'b1;
            i++;
        end
        $display("[TB] test_async_reset: %0d frames checked", i + 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_restart("test_download", 1'b1);
        test_restart("test_normal", 1'b0);
        test_ignore_and_passthru();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
